// File: rtl/hazard_pkg.sv
// Shared types for the hazard unit: forwarding selects, per-stage shadow tags
// and the bubble tag.
package hazard_pkg;

  localparam int TAG_AW = 5;
  localparam logic [TAG_AW-1:0] REG_X0 = {TAG_AW{1'b0}};

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic [TAG_AW-1:0] rd;
    logic [TAG_AW-1:0] rs1;
    logic [TAG_AW-1:0] rs2;
    logic              regwrite;
    logic              load;
  } stage_tag_t;

  localparam stage_tag_t BUBBLE_TAG = '{
    rd: REG_X0, rs1: REG_X0, rs2: REG_X0, regwrite: 1'b0, load: 1'b0
  };

  // True when a stage's destination is a real register equal to rs.
  function automatic logic rd_hits(input stage_tag_t t, input logic [TAG_AW-1:0] rs);
    return (t.rd != REG_X0) && (t.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_if.sv
// Decode/datapath <-> hazard unit bundle. The master side is the pipeline,
// the slave side is the hazard unit.
interface hazard_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) ();
  import hazard_pkg::*;

  logic [REG_AW-1:0] Rs1D;
  logic [REG_AW-1:0] Rs2D;
  logic [REG_AW-1:0] RdD;
  logic              RegWriteD;
  logic              LoadD;
  logic              PCSrcE;
  fwd_sel_t          ForwardAE;
  fwd_sel_t          ForwardBE;
  logic              StallF;
  logic              StallD;
  logic              FlushD;
  logic              FlushE;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output Rs1D, Rs2D, RdD, RegWriteD, LoadD, PCSrcE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, stall_cnt, flush_cnt
  );

  modport slave (
    input  Rs1D, Rs2D, RdD, RegWriteD, LoadD, PCSrcE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_fwd_sel.sv
// Operand forwarding select for one execute-stage source register.
// M beats W; loads in M never forward because their data is not ready yet.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [TAG_AW-1:0] i_rs_e,
  input  logic [TAG_AW-1:0] i_rd_m,
  input  logic              i_regwrite_m,
  input  logic              i_load_m,
  input  logic [TAG_AW-1:0] i_rd_w,
  input  logic              i_regwrite_w,
  output fwd_sel_t          o_sel
);

  // Priority compare against the two younger-to-older producers.
  always_comb begin
    o_sel = FWD_RF;
    if (i_regwrite_m && !i_load_m && (i_rd_m != REG_X0) && (i_rd_m == i_rs_e)) begin
      o_sel = FWD_MEM;
    end else if (i_regwrite_w && (i_rd_w != REG_X0) && (i_rd_w == i_rs_e)) begin
      o_sel = FWD_WB;
    end else begin
      o_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit for a 5-stage pipeline: shadow E/M/W tags, operand forwarding,
// load-use stall, branch flush and saturating stall/flush event counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input logic     clk,
  input logic     rst_n,
  hazard_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  stage_tag_t       w_tag_d;
  stage_tag_t       r_tag_e;
  stage_tag_t       r_tag_m;
  stage_tag_t       r_tag_w;
  logic             w_lw_stall;
  logic             w_flush_e;
  fwd_sel_t         w_fwd_a;
  fwd_sel_t         w_fwd_b;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_unused_tag;

  // Decode-stage fields packed into a tag.
  always_comb begin
    w_tag_d          = BUBBLE_TAG;
    w_tag_d.rd       = TAG_AW'(bus.RdD);
    w_tag_d.rs1      = TAG_AW'(bus.Rs1D);
    w_tag_d.rs2      = TAG_AW'(bus.Rs2D);
    w_tag_d.regwrite = bus.RegWriteD;
    w_tag_d.load     = bus.LoadD;
  end

  // A taken branch discards the wrong-path load-use, so it masks the stall.
  assign w_lw_stall = r_tag_e.load && !bus.PCSrcE &&
                      (rd_hits(r_tag_e, w_tag_d.rs1) || rd_hits(r_tag_e, w_tag_d.rs2));
  assign w_flush_e  = w_lw_stall || bus.PCSrcE;

  hazard_fwd_sel u_fwd_a (
    .i_rs_e       (r_tag_e.rs1),
    .i_rd_m       (r_tag_m.rd),
    .i_regwrite_m (r_tag_m.regwrite),
    .i_load_m     (r_tag_m.load),
    .i_rd_w       (r_tag_w.rd),
    .i_regwrite_w (r_tag_w.regwrite),
    .o_sel        (w_fwd_a)
  );

  hazard_fwd_sel u_fwd_b (
    .i_rs_e       (r_tag_e.rs2),
    .i_rd_m       (r_tag_m.rd),
    .i_regwrite_m (r_tag_m.regwrite),
    .i_load_m     (r_tag_m.load),
    .i_rd_w       (r_tag_w.rd),
    .i_regwrite_w (r_tag_w.regwrite),
    .o_sel        (w_fwd_b)
  );

  // Shadow pipe; never stalls because every stall also flushes E.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_e <= BUBBLE_TAG;
      r_tag_m <= BUBBLE_TAG;
      r_tag_w <= BUBBLE_TAG;
    end else begin
      r_tag_e <= w_flush_e ? BUBBLE_TAG : w_tag_d;
      r_tag_m <= r_tag_e;
      r_tag_w <= r_tag_m;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= CNT_ZERO;
      r_flush_cnt <= CNT_ZERO;
    end else begin
      if (w_lw_stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (bus.PCSrcE && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  assign w_unused_tag = ^{r_tag_m.rs1, r_tag_m.rs2, r_tag_w.rs1, r_tag_w.rs2, r_tag_w.load};

  assign bus.ForwardAE = w_fwd_a;
  assign bus.ForwardBE = w_fwd_b;
  assign bus.StallF    = w_lw_stall;
  assign bus.StallD    = w_lw_stall;
  assign bus.FlushD    = bus.PCSrcE;
  assign bus.FlushE    = w_flush_e;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a per-cycle vector table for forwarding and
// stall/flush, plus sequences for reset, mid-stall reset and counter saturation.
module tb_hazard_unit;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_if #(.REG_AW(5), .CNT_W(32)) hz ();
  hazard_if #(.REG_AW(5), .CNT_W(2))  hz_s ();

  hazard_unit #(.REG_AW(5), .CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(hz));
  hazard_unit #(.REG_AW(5), .CNT_W(2))  dut_s (.clk(clk), .rst_n(rst_n), .bus(hz_s));

  assign hz_s.Rs1D      = hz.Rs1D;
  assign hz_s.Rs2D      = hz.Rs2D;
  assign hz_s.RdD       = hz.RdD;
  assign hz_s.RegWriteD = hz.RegWriteD;
  assign hz_s.LoadD     = hz.LoadD;
  assign hz_s.PCSrcE    = hz.PCSrcE;

  typedef struct {
    int rs1, rs2, rd, rw, ld, pc;
    int fa, fb, st, fe, sc, fc;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(int rs1, int rs2, int rd, int rw, int ld, int pc,
                              int fa, int fb, int st, int fe, int sc, int fc);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.rw = rw; v.ld = ld; v.pc = pc;
    v.fa = fa; v.fb = fb; v.st = st; v.fe = fe; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int rs1, input int rs2, input int rd, input int rw,
                       input int ld, input int pc);
    hz.Rs1D = rs1[4:0]; hz.Rs2D = rs2[4:0]; hz.RdD = rd[4:0];
    hz.RegWriteD = rw[0]; hz.LoadD = ld[0]; hz.PCSrcE = pc[0];
  endtask

  task automatic chk_outs(input string tag, input int fa, input int fb, input int st,
                          input int fd, input int fe);
    chk({tag, ".fa"}, 64'(hz.ForwardAE), 64'(fa));
    chk({tag, ".fb"}, 64'(hz.ForwardBE), 64'(fb));
    chk({tag, ".stallF"}, 64'(hz.StallF), 64'(st));
    chk({tag, ".stallD"}, 64'(hz.StallD), 64'(st));
    chk({tag, ".flushD"}, 64'(hz.FlushD), 64'(fd));
    chk({tag, ".flushE"}, 64'(hz.FlushE), 64'(fe));
  endtask

  initial begin
    //                 rs1 rs2 rd rw ld pc  fa fb st fe sc fc
    vecs[0]  = mk( 1,  2,  3, 1, 0, 0,  0, 0, 0, 0, 0, 0); // add x3,x1,x2
    vecs[1]  = mk(11, 12, 10, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(14, 15, 13, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(17, 18, 16, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[4]  = mk( 1,  2,  5, 1, 0, 0,  0, 0, 0, 0, 0, 0); // add x5
    vecs[5]  = mk( 5,  7,  6, 1, 0, 0,  0, 0, 0, 0, 0, 0); // sub x6,x5,x7
    vecs[6]  = mk( 0,  0,  0, 0, 0, 0,  2, 0, 0, 0, 0, 0); // sub in E: A from M
    vecs[7]  = mk( 1,  2,  5, 1, 0, 0,  0, 0, 0, 0, 0, 0); // add x5
    vecs[8]  = mk( 0,  0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0); // nop
    vecs[9]  = mk( 1,  5,  8, 1, 0, 0,  0, 0, 0, 0, 0, 0); // or x8,x1,x5
    vecs[10] = mk( 0,  0,  0, 0, 0, 0,  0, 1, 0, 0, 0, 0); // or in E: B from W
    vecs[11] = mk( 1,  2,  5, 1, 0, 0,  0, 0, 0, 0, 0, 0); // add x5
    vecs[12] = mk( 3,  4,  5, 1, 0, 0,  0, 0, 0, 0, 0, 0); // add x5
    vecs[13] = mk( 5,  5,  9, 1, 0, 0,  0, 0, 0, 0, 0, 0); // and x9,x5,x5
    vecs[14] = mk( 0,  0,  0, 0, 0, 0,  2, 2, 0, 0, 0, 0); // M wins over W
    vecs[15] = mk( 1,  0,  4, 1, 1, 0,  0, 0, 0, 0, 0, 0); // lw x4
    vecs[16] = mk( 4,  1,  9, 1, 0, 0,  0, 0, 1, 1, 0, 0); // add x9,x4,x1: stall
    vecs[17] = mk( 4,  1,  9, 1, 0, 0,  0, 0, 0, 0, 1, 0); // held, bubble in E
    vecs[18] = mk( 0,  0,  0, 0, 0, 0,  1, 0, 0, 0, 1, 0); // add in E: A from W
    vecs[19] = mk( 1,  0,  0, 1, 1, 0,  0, 0, 0, 0, 1, 0); // lw x0
    vecs[20] = mk( 0,  1,  9, 1, 0, 0,  0, 0, 0, 0, 1, 0); // add x9,x0,x1: no stall
    vecs[21] = mk( 0,  0,  0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
    vecs[22] = mk( 1,  0,  4, 1, 1, 0,  0, 0, 0, 0, 1, 0); // lw x4
    vecs[23] = mk( 4,  1,  9, 1, 0, 1,  0, 0, 0, 1, 1, 0); // branch beats stall
    vecs[24] = mk( 0,  0,  0, 0, 0, 0,  0, 0, 0, 0, 1, 1);

    // While in reset: everything clear, flushes follow PCSrcE.
    drive(0, 0, 0, 0, 0, 1);
    #3;
    chk_outs("reset", 0, 0, 0, 1, 1);
    chk("reset.stall_cnt", 64'(hz.stall_cnt), 64'd0);
    chk("reset.flush_cnt", 64'(hz.flush_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].rw, vecs[i].ld, vecs[i].pc);
      #1;
      chk_outs($sformatf("v%0d", i), vecs[i].fa, vecs[i].fb, vecs[i].st, vecs[i].pc, vecs[i].fe);
      chk($sformatf("v%0d.stall_cnt", i), 64'(hz.stall_cnt), 64'(vecs[i].sc));
      chk($sformatf("v%0d.flush_cnt", i), 64'(hz.flush_cnt), 64'(vecs[i].fc));
    end

    // Reset asserted in the middle of a stall cycle drops everything at once.
    @(negedge clk);
    drive(1, 0, 4, 1, 1, 0);
    @(negedge clk);
    drive(4, 1, 9, 1, 0, 0);
    #1;
    chk("midrst.pre_stall", 64'(hz.StallD), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("midrst", 0, 0, 0, 0, 0);
    chk("midrst.stall_cnt", 64'(hz.stall_cnt), 64'd0);
    chk("midrst.flush_cnt", 64'(hz.flush_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    // Five load-use stalls, then five taken branches.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1, 0, 4, 1, 1, 0);
      @(negedge clk);
      drive(4, 1, 9, 1, 0, 0);
      #1;
      chk($sformatf("sat%0d.stallD", k), 64'(hz.StallD), 64'd1);
      @(negedge clk);
      drive(4, 1, 9, 1, 0, 0);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 1);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("sat.stall_cnt32", 64'(hz.stall_cnt), 64'd5);
    chk("sat.flush_cnt32", 64'(hz.flush_cnt), 64'd5);
    chk("sat.stall_cnt2", 64'(hz_s.stall_cnt), 64'd3);
    chk("sat.flush_cnt2", 64'(hz_s.flush_cnt), 64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
